// File: rtl/snake_io_pkg.sv
// Shared constants, FSM state type and display ring table for the snake IO master.
package snake_io_pkg;

    // IO bus addresses of the peripherals this master talks to
    localparam logic [3:0] IO_ADDR_DISP  = 4'b0000;
    localparam logic [3:0] IO_ADDR_SPEED = 4'b0100;

    // Ring geometry: 12 outer segments, snake body of 3 segments
    localparam int RING_LEN  = 12;
    localparam int SNAKE_LEN = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        WAIT  = 2'd3
    } state_t;

    // Display-register bit lit by each ring position, walking clockwise
    // around the outer edge of the four digits.
    localparam logic [4:0] RING_BIT [RING_LEN] = '{
        5'd21, 5'd14, 5'd7,  5'd0,  5'd1,  5'd2,
        5'd3,  5'd10, 5'd17, 5'd24, 5'd25, 5'd26
    };

    // Advance a ring position, wrapping after the last segment
    function automatic logic [3:0] next_pos(input logic [3:0] p);
        return (p == 4'(RING_LEN - 1)) ? 4'd0 : p + 4'd1;
    endfunction

endpackage

// File: rtl/snake_ring_pattern.sv
// Combinational decoder: ring position of the snake head -> 28-bit display
// pattern with the head and the two segments behind it lit.
module snake_ring_pattern
    import snake_io_pkg::*;
(
    input  logic [3:0]  pos,
    output logic [27:0] pattern
);

    // Light the head segment and the SNAKE_LEN-1 segments trailing it
    always_comb begin
        pattern = '0;
        for (int k = 0; k < SNAKE_LEN; k++) begin
            int p;
            p = int'(pos) - k;
            if (p < 0) begin
                p = p + RING_LEN;
            end
            pattern[RING_BIT[4'(p)]] = 1'b1;
        end
    end

endmodule

// File: rtl/snake_io_master.sv
// IO bus initiator that animates a 3-segment snake on the display register.
// Each step: one display write, one speed read, then a wait whose length
// doubles for every step the speed switches are below 3.
// Bus handshake: there is no valid/ready; IOWriteEn is a single-cycle write
// strobe qualified by IOAddr/IOWriteData in the same cycle, and IOReadData is
// sampled at the clock edge closing the cycle in which IOAddr selects the
// speed peripheral.
module snake_io_master
    import snake_io_pkg::*;
#(
    parameter int BASE_DELAY = 1048576,
    parameter int CNT_W      = 24
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        ENABLE,
    output logic [3:0]  IOAddr,
    output logic [31:0] IOWriteData,
    output logic        IOWriteEn,
    input  logic [31:0] IOReadData
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       pos;
    logic [1:0]       speed_q;
    logic [CNT_W-1:0] cnt;
    logic [27:0]      pattern;

    // Only the two speed bits of the peripheral word matter; the rest of the
    // word and the stored speed are kept for visibility only.
    logic unused_bits;
    assign unused_bits = ^{IOReadData[31:2], speed_q};

    // Wait length for a given speed: BASE_DELAY at speed 3, 8x at speed 0
    function automatic logic [CNT_W-1:0] wait_len(input logic [1:0] spd);
        return CNT_W'(BASE_DELAY) << (2'd3 - spd);
    endfunction

    snake_ring_pattern u_pattern (
        .pos     (pos),
        .pattern (pattern)
    );

    // State register
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and bus control decoded from the current state only
    always_comb begin
        state_nxt = state;
        IOAddr    = IO_ADDR_DISP;
        IOWriteEn = 1'b0;
        case (state)
            IDLE: begin
                if (ENABLE) begin
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                IOWriteEn = 1'b1;
                state_nxt = READ;
            end
            READ: begin
                IOAddr    = IO_ADDR_SPEED;
                state_nxt = ENABLE ? WAIT : IDLE;
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_nxt = WRITE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: write-data register, ring position, speed and wait counter
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            IOWriteData <= 32'h0;
            pos         <= 4'd0;
            speed_q     <= 2'd0;
            cnt         <= '0;
        end else begin
            // Load the frame on entry to WRITE so the bus data comes from a flop
            if (state_nxt == WRITE) begin
                IOWriteData <= {4'h0, pattern};
            end
            if (state == WRITE) begin
                pos <= next_pos(pos);
            end
            if (state == READ && ENABLE) begin
                speed_q <= IOReadData[1:0];
                cnt     <= wait_len(IOReadData[1:0]) - CNT_ONE;
            end else if (state == WAIT && cnt != '0) begin
                cnt <= cnt - CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_snake_io_master.sv
// Directed bench for snake_io_master with BASE_DELAY=4: a stimulus process
// pushes expected display writes (data and spacing from the previous write)
// and a monitor pops them whenever the DUT strobes IOWriteEn.
module tb_snake_io_master;

    localparam int W = 40;

    logic        CLK;
    logic        RESET_N;
    logic        ENABLE;
    logic [3:0]  IOAddr;
    logic [31:0] IOWriteData;
    logic        IOWriteEn;
    logic [31:0] IOReadData;

    logic [1:0]  sw;
    logic [29:0] rd_upper;

    logic [W-1:0] exp_q[$];

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;
    int cyc    = 0;
    int wr_seen = 0;
    int last_wr_cyc = 0;
    logic        prev_we = 1'b0;
    logic [31:0] last_data = 32'h0;

    // Hand-computed display frames for head positions 0..11
    logic [31:0] pat [12] = '{
        32'h06200000, 32'h04204000, 32'h00204080, 32'h00004081,
        32'h00000083, 32'h00000007, 32'h0000000E, 32'h0000040C,
        32'h00020408, 32'h01020400, 32'h03020000, 32'h07000000
    };

    snake_io_master #(
        .BASE_DELAY (4),
        .CNT_W      (8)
    ) dut (
        .CLK         (CLK),
        .RESET_N     (RESET_N),
        .ENABLE      (ENABLE),
        .IOAddr      (IOAddr),
        .IOWriteData (IOWriteData),
        .IOWriteEn   (IOWriteEn),
        .IOReadData  (IOReadData)
    );

    // Speed peripheral model: responds combinationally at address 0100
    assign IOReadData = (IOAddr == 4'b0100) ? {rd_upper, sw} : 32'h0;

    // Clock
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic push_wr(input int gap, input logic [31:0] data);
        exp_q.push_back({8'(gap), data});
    endtask

    task automatic wait_writes(input int n);
        int budget;
        budget = 200;
        while (wr_seen < n && budget > 0) begin
            @(negedge CLK);
            budget--;
        end
        chk("write_count", 32'(wr_seen), 32'(n));
    endtask

    task automatic skip(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Monitor / scoreboard: checks bus every cycle, pops on each write
    always begin
        logic [W-1:0] e;
        @(posedge CLK);
        #2;
        cyc++;
        if (!RESET_N) begin
            chk("rst_mon_we", 32'(IOWriteEn), 32'h0);
            prev_we   = 1'b0;
            last_data = 32'h0;
        end else begin
            chk("addr", 32'(IOAddr), prev_we ? 32'h4 : 32'h0);
            if (IOWriteEn) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 32'h1, 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_data", IOWriteData, e[31:0]);
                    if (e[39:32] != 8'd0) begin
                        chk("wr_gap", 32'(cyc - last_wr_cyc), 32'(e[39:32]));
                    end
                    last_data = e[31:0];
                end
                last_wr_cyc = cyc;
                wr_seen++;
            end else begin
                chk("hold_data", IOWriteData, last_data);
            end
            prev_we = IOWriteEn;
        end
    end

    // Stimulus
    initial begin
        RESET_N  = 1'b0;
        ENABLE   = 1'b1;
        sw       = 2'd3;
        rd_upper = '0;

        // Reset held with ENABLE high: bus stays quiet
        repeat (3) begin
            @(negedge CLK);
            chk("rst_addr", 32'(IOAddr), 32'h0);
            chk("rst_data", IOWriteData, 32'h0);
            chk("rst_we", 32'(IOWriteEn), 32'h0);
        end

        // Speed 3: period 6; switch to speed 0 mid-WAIT after the second write
        push_wr(0, pat[0]);
        push_wr(6, pat[1]);
        push_wr(6, pat[2]);
        push_wr(34, pat[3]);
        RESET_N = 1'b1;
        wait_writes(2);
        skip(2);
        sw = 2'd0;
        wait_writes(4);

        // Back to speed 3 mid-WAIT: one more long period, then short
        skip(2);
        sw = 2'd3;
        push_wr(34, pat[4]);
        push_wr(6, pat[5]);
        wait_writes(6);

        // Speed 2 with all upper read bits set: D = 8
        skip(2);
        sw = 2'd2;
        rd_upper = '1;
        push_wr(6, pat[6]);
        push_wr(10, pat[7]);
        wait_writes(8);

        // Speed 3 through the end of the ring and wrap to position 0
        skip(2);
        sw = 2'd3;
        rd_upper = '0;
        push_wr(10, pat[8]);
        push_wr(6, pat[9]);
        push_wr(6, pat[10]);
        push_wr(6, pat[11]);
        push_wr(6, pat[0]);
        wait_writes(13);

        // Drop ENABLE mid-WAIT: one more write, then idle
        skip(2);
        ENABLE = 1'b0;
        push_wr(6, pat[1]);
        wait_writes(14);
        skip(20);
        chk("idle_no_write", 32'(wr_seen), 32'd14);

        // Re-enable: continues from the next ring position
        push_wr(0, pat[2]);
        ENABLE = 1'b1;
        wait_writes(15);

        // Reset mid-WAIT clears the outputs immediately
        skip(2);
        RESET_N = 1'b0;
        ENABLE  = 1'b0;
        #1;
        chk("midrst_addr", 32'(IOAddr), 32'h0);
        chk("midrst_data", IOWriteData, 32'h0);
        chk("midrst_we", 32'(IOWriteEn), 32'h0);
        skip(2);
        RESET_N = 1'b1;
        skip(5);
        chk("post_rst_idle", 32'(wr_seen), 32'd15);

        // After reset the ring restarts at position 0
        push_wr(0, pat[0]);
        ENABLE = 1'b1;
        wait_writes(16);
        chk("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
